mem_port_arbiter: RTL and testbench

Shares the single word-wide main-memory port between two requesters: port 0 is the instruction-side cache and port 1 is the data-side cache. Each requester issues one-word read or write transactions with a req/done handshake. The arbiter sequences the fixed-latency memory access for each transaction and arbitrates round-robin between the ports. A lock input lets a requester keep the port across back-to-back transactions, such as a dirty-line write-back followed by a refill.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one word-wide main-memory port between the instruction-side cache
//   (port 0) and the data-side cache (port 1). Each granted transaction walks
//   IDLE -> ISSUE -> WAIT -> RESP. Ports are served round-robin, and a port can
//   keep the memory across back-to-back transactions by holding lock at done.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-low reset
//   reqN, weN, addrN,       per-port request, write enable, byte address,
//   wdataN, lockN           write word and keep-grant request
//   rdataN, doneN, gntN     per-port registered read word, completion pulse, grant
//   busy                    high whenever a transaction is in flight
//   mem_addr, mem_we,       memory request (word-aligned address, one-cycle
//   mem_wdata               write strobe, write word)
//   mem_rdata               read word from memory, valid MEM_LATENCY edges
//                           after the address is sampled
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        done0,
    output logic        done1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cur_port;
    logic             cur_we;
    // 2'b00: no grant since reset (port 0 wins a tie), 2'b01: port 0 was last,
    // 2'b10: port 1 was last.
    logic [1:0]       last_grant;
    logic             hold_vld;
    logic             hold_port;

    logic             hold_req;
    logic             hold_hit;
    logic             grant_vld;
    logic             grant_port;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;

    // Arbitration: a pending lock-hold wins only while its owner still requests.
    always_comb begin
        hold_req  = hold_port ? req1 : req0;
        hold_hit  = hold_vld && hold_req;
        grant_vld = req0 || req1;
        if (hold_hit) begin
            grant_port = hold_port;
        end else if (req0 && req1) begin
            grant_port = (last_grant == 2'b01);
        end else begin
            grant_port = req1;
        end
        sel_we    = grant_port ? we1    : we0;
        sel_addr  = grant_port ? addr1  : addr0;
        sel_wdata = grant_port ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata0     <= '0;
            rdata1     <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            cnt        <= '0;
            cur_port   <= 1'b0;
            cur_we     <= 1'b0;
            last_grant <= 2'b00;
            hold_vld   <= 1'b0;
            hold_port  <= 1'b0;
        end else begin
            case (state)
                // IDLE: latch the winner and present its request to memory
                IDLE: begin
                    if (hold_vld && !hold_req) begin
                        hold_vld <= 1'b0;
                    end
                    if (grant_vld) begin
                        cur_port  <= grant_port;
                        cur_we    <= sel_we;
                        gnt0      <= !grant_port;
                        gnt1      <= grant_port;
                        busy      <= 1'b1;
                        mem_addr  <= sel_addr & 32'hFFFF_FFFC;
                        mem_we    <= sel_we;
                        mem_wdata <= sel_wdata;
                    end
                end
                // ISSUE: memory samples the request at this edge
                ISSUE: begin
                    mem_we <= 1'b0;
                    cnt    <= CNT_W'(MEM_LATENCY - 1);
                end
                // WAIT: count down the fixed latency, then capture and signal done
                WAIT: begin
                    if (cnt == '0) begin
                        if (!cur_we) begin
                            if (cur_port) rdata1 <= mem_rdata;
                            else          rdata0 <= mem_rdata;
                        end
                        done0 <= !cur_port;
                        done1 <= cur_port;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // RESP: release the port and remember who had it
                RESP: begin
                    done0      <= 1'b0;
                    done1      <= 1'b0;
                    gnt0       <= 1'b0;
                    gnt1       <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= cur_port ? 2'b10 : 2'b01;
                    hold_vld   <= cur_port ? lock1 : lock0;
                    hold_port  <= cur_port;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomized bench for mem_port_arbiter. Two requester agents issue
//   transactions; a memory device model answers the DUT's memory port. A
//   transaction-level reference model predicts, from the grant edge and plain
//   edge-count arithmetic, when each output is high and what each rdata holds.
module tb_mem_port_arbiter;

    localparam int LAT   = 4;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        done0, done1, gnt0, gnt1, busy;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    // Agent-side request fields
    logic [1:0]  a_req;
    logic [1:0]  a_we;
    logic [1:0]  a_lock;
    logic [31:0] a_addr  [2];
    logic [31:0] a_wdata [2];

    assign req0   = a_req[0];
    assign req1   = a_req[1];
    assign we0    = a_we[0];
    assign we1    = a_we[1];
    assign lock0  = a_lock[0];
    assign lock1  = a_lock[1];
    assign addr0  = a_addr[0];
    assign addr1  = a_addr[1];
    assign wdata0 = a_wdata[0];
    assign wdata1 = a_wdata[1];

    mem_port_arbiter #(.MEM_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .lock0     (lock0),
        .lock1     (lock1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .done0     (done0),
        .done1     (done1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory device: writes on mem_we, read data is the word whose address was
    // sampled LAT edges earlier.
    logic [31:0] dev_mem [64];
    logic [5:0]  rd_pipe [LAT];

    always @(posedge clk) begin
        if (mem_we) dev_mem[mem_addr[7:2]] <= mem_wdata;
        rd_pipe[0] <= mem_addr[7:2];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_rdata = dev_mem[rd_pipe[LAT-1]];

    // Reference model state
    int          edge_n;
    bit          in_txn;
    int          g_edge;
    int          mp;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          last;
    bit          hold_v;
    int          hold_p;
    logic [31:0] model_mem [64];
    logic [31:0] exp_rdata [2];
    bit          e_gnt  [2];
    bit          e_done [2];
    bit          e_busy;
    bit          e_we;

    // Agent control
    int          left      [2];
    bit          keep_lock [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        in_txn       = 1'b0;
        last         = -1;
        hold_v       = 1'b0;
        hold_p       = 0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        e_gnt[0]     = 1'b0;
        e_gnt[1]     = 1'b0;
        e_done[0]    = 1'b0;
        e_done[1]    = 1'b0;
        e_busy       = 1'b0;
        e_we         = 1'b0;
    endtask

    // One clock edge of the transaction-level model: a transaction granted at
    // edge g occupies the port until edge g+LAT+2; done is seen after g+LAT+1.
    task automatic model_step();
        int k;
        int w;
        edge_n++;
        if (!in_txn) begin
            if (hold_v && !a_req[hold_p]) hold_v = 1'b0;
            if (a_req[0] || a_req[1]) begin
                if (hold_v)                    w = hold_p;
                else if (a_req[0] && a_req[1]) w = (last == 0) ? 1 : 0;
                else                           w = a_req[1] ? 1 : 0;
                in_txn  = 1'b1;
                g_edge  = edge_n;
                mp      = w;
                m_we    = a_we[w];
                m_addr  = a_addr[w];
                m_wdata = a_wdata[w];
                if (m_we) model_mem[m_addr[7:2]] = m_wdata;
            end
        end else begin
            k = edge_n - g_edge;
            if (k == LAT + 1 && !m_we) exp_rdata[mp] = model_mem[m_addr[7:2]];
            if (k == LAT + 2) begin
                last   = mp;
                hold_v = a_lock[mp];
                hold_p = mp;
                in_txn = 1'b0;
            end
        end
        k         = edge_n - g_edge;
        e_gnt[0]  = in_txn && (mp == 0);
        e_gnt[1]  = in_txn && (mp == 1);
        e_busy    = in_txn;
        e_we      = in_txn && (k == 0) && m_we;
        e_done[0] = in_txn && (mp == 0) && (k == LAT + 1);
        e_done[1] = in_txn && (mp == 1) && (k == LAT + 1);
    endtask

    task automatic check_outputs();
        check_val("done0",  done0,  e_done[0]);
        check_val("done1",  done1,  e_done[1]);
        check_val("gnt0",   gnt0,   e_gnt[0]);
        check_val("gnt1",   gnt1,   e_gnt[1]);
        check_val("busy",   busy,   e_busy);
        check_val("mem_we", mem_we, e_we);
        check_val("rdata0", rdata0, exp_rdata[0]);
        check_val("rdata1", rdata1, exp_rdata[1]);
        if (e_busy) check_val("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
        if (e_we)   check_val("mem_wdata", mem_wdata, m_wdata);
    endtask

    task automatic set_txn(input int p, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit lk);
        a_req[p]   = 1'b1;
        a_we[p]    = we;
        a_addr[p]  = addr;
        a_wdata[p] = wdata;
        a_lock[p]  = lk;
    endtask

    task automatic new_txn(input int p, input bit lk);
        set_txn(p, 1'($urandom_range(0, 1)), $urandom, $urandom, lk);
    endtask

    task automatic drive(input bit rnd);
        for (int p = 0; p < 2; p++) begin
            if (e_done[p] && a_req[p]) begin
                if (rnd) begin
                    if ($urandom_range(0, 1) == 1) begin
                        new_txn(p, $urandom_range(0, 2) == 0);
                    end else begin
                        a_req[p]  = 1'b0;
                        a_lock[p] = 1'($urandom_range(0, 1));
                    end
                end else if (left[p] > 0) begin
                    left[p]--;
                    new_txn(p, (left[p] > 0) ? keep_lock[p] : 1'b0);
                end else begin
                    a_req[p]  = 1'b0;
                    a_lock[p] = 1'b0;
                end
            end else if (rnd && !a_req[p] && $urandom_range(0, 3) == 0) begin
                new_txn(p, $urandom_range(0, 2) == 0);
            end
        end
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
            drive(rnd);
        end
    endtask

    initial begin
        logic [31:0] v;
        reset    = 1'b0;
        a_req    = '0;
        a_we     = '0;
        a_lock   = '0;
        for (int p = 0; p < 2; p++) begin
            a_addr[p]    = '0;
            a_wdata[p]   = '0;
            left[p]      = 0;
            keep_lock[p] = 1'b0;
        end
        for (int i = 0; i < 64; i++) begin
            v            = $urandom;
            dev_mem[i]   = v;
            model_mem[i] = v;
        end
        dev_mem[1]   = 32'hDEAD_BEEF;
        model_mem[1] = 32'hDEAD_BEEF;
        edge_n = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check_val("reset_busy",  busy,     1'b0);
        check_val("reset_gnt",   {gnt1, gnt0}, 2'b00);
        check_val("reset_maddr", mem_addr, 32'h0);
        reset = 1'b1;

        // Single read on port 0
        set_txn(0, 1'b0, 32'h0000_1004, 32'h0, 1'b0);
        run_cycles(LAT + 6, 1'b0);
        check_val("read_deadbeef", rdata0, 32'hDEAD_BEEF);

        // Single write on port 1 with an unaligned address
        set_txn(1, 1'b1, 32'h0000_2003, 32'h1122_3344, 1'b0);
        run_cycles(LAT + 6, 1'b0);
        check_val("write_rdata1", rdata1, 32'h0);

        // Both rise together, two transactions each: expect 0,1,0,1
        left[0] = 1;
        left[1] = 1;
        set_txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        set_txn(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        run_cycles(4 * (LAT + 3) + 4, 1'b0);

        // Port 1 locks across a write and a read while port 0 waits; the
        // second done carries lock low, so port 0 gets in before port 1's third
        left[1]      = 2;
        keep_lock[1] = 1'b1;
        set_txn(1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b1);
        run_cycles(1, 1'b0);
        set_txn(0, 1'b0, 32'h0000_0030, 32'h0, 1'b0);
        run_cycles(4 * (LAT + 3) + 4, 1'b0);
        keep_lock[1] = 1'b0;

        // Randomized traffic
        run_cycles(3000, 1'b1);

        // Drain, then reset in the middle of a port-0 read
        a_req = '0;
        a_lock = '0;
        run_cycles(2 * (LAT + 3), 1'b0);
        check_val("drained_busy", busy, 1'b0);
        set_txn(0, 1'b0, 32'h0000_0044, 32'h0, 1'b0);
        run_cycles((LAT > 1) ? 3 : 2, 1'b0);
        #1 reset = 1'b0;
        #1;
        check_val("rst_done0",  done0,     1'b0);
        check_val("rst_done1",  done1,     1'b0);
        check_val("rst_gnt0",   gnt0,      1'b0);
        check_val("rst_gnt1",   gnt1,      1'b0);
        check_val("rst_busy",   busy,      1'b0);
        check_val("rst_maddr",  mem_addr,  32'h0);
        check_val("rst_mwe",    mem_we,    1'b0);
        check_val("rst_mwdata", mem_wdata, 32'h0);
        check_val("rst_rdata0", rdata0,    32'h0);
        check_val("rst_rdata1", rdata1,    32'h0);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_val("rst_hold_done0", done0, 1'b0);
        end
        reset = 1'b1;
        run_cycles(LAT + 8, 1'b0);
        check_val("reissue_rdata0", rdata0, model_mem[6'h11]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
